// File: rtl/dvs_event_mem_writer.sv
// DVS frame memory writer: CAVIAR events to {ts, pol} words at [x][y].
// Sweeps the frame to zero after reset or on request.
module dvs_event_mem_writer #(
  parameter int DVS_WIDTH       = 346,
  parameter int DVS_HEIGHT      = 260,
  parameter int WORD_SIZE       = 18,
  parameter int CAVIAR_X_Y_BITS = 9,
  parameter int TIMESTAMP_BITS  = 16,
  parameter int POLARITY_BITS   = 2,
  parameter int ADDR_BITS       = 17
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [CAVIAR_X_Y_BITS-1:0] s_x,
  input  logic [CAVIAR_X_Y_BITS-1:0] s_y,
  input  logic [TIMESTAMP_BITS-1:0]  s_ts,
  input  logic [POLARITY_BITS-1:0]   s_pol,
  input  logic                       clear_start,
  output logic                       busy,
  output logic                       mem_we,
  output logic [ADDR_BITS-1:0]       mem_addr,
  output logic [WORD_SIZE-1:0]       mem_wdata,
  output logic [15:0]                accept_cnt,
  output logic [15:0]                drop_cnt
);

  localparam int N_PIX = DVS_WIDTH * DVS_HEIGHT;
  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(N_PIX - 1);

  localparam logic [1:0] ST_CLEAR = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]                 state_q, state_d;
  logic [ADDR_BITS-1:0]       clr_addr_q, clr_addr_d;
  logic                       drain_q, drain_d;

  logic                       s1_vld_q, s1_vld_d;
  logic [CAVIAR_X_Y_BITS-1:0] s1_x_q, s1_x_d;
  logic [CAVIAR_X_Y_BITS-1:0] s1_y_q, s1_y_d;
  logic [TIMESTAMP_BITS-1:0]  s1_ts_q, s1_ts_d;
  logic [POLARITY_BITS-1:0]   s1_pol_q, s1_pol_d;

  logic                       s2_vld_q, s2_vld_d;
  logic [ADDR_BITS-1:0]       s2_addr_q, s2_addr_d;
  logic [WORD_SIZE-1:0]       s2_data_q, s2_data_d;

  logic                       mem_we_q, mem_we_d;
  logic [ADDR_BITS-1:0]       mem_addr_q, mem_addr_d;
  logic [WORD_SIZE-1:0]       mem_wdata_q, mem_wdata_d;
  logic [15:0]                acc_q, acc_d;
  logic [15:0]                drop_q, drop_d;

  logic                       accept;
  logic                       ev_ok;
  logic [31:0]                x_ext, y_ext;

  assign s_ready    = (state_q == ST_RUN) && !clear_start;
  assign busy       = (state_q != ST_RUN);
  assign accept     = s_valid && s_ready;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign accept_cnt = acc_q;
  assign drop_cnt   = drop_q;

  assign x_ext = {{(32-CAVIAR_X_Y_BITS){1'b0}}, s1_x_q};
  assign y_ext = {{(32-CAVIAR_X_Y_BITS){1'b0}}, s1_y_q};

  // Only the two single-hot polarity codes are real events
  assign ev_ok = (x_ext < 32'(DVS_WIDTH))
              && (y_ext < 32'(DVS_HEIGHT))
              && ((s1_pol_q == POLARITY_BITS'(1))
               || (s1_pol_q == POLARITY_BITS'(2)));

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    drain_d    = drain_q;
    unique case (state_q)
      ST_CLEAR: begin
        clr_addr_d = clr_addr_q + 1'b1;
        if (clr_addr_q == LAST_ADDR) begin
          clr_addr_d = '0;
          state_d    = ST_RUN;
        end
      end
      ST_RUN: begin
        drain_d = 1'b0;
        if (clear_start) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        drain_d = 1'b1;
        if (drain_q) state_d = ST_CLEAR;
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  always_comb begin
    s1_vld_d = accept;
    s1_x_d   = s1_x_q;
    s1_y_d   = s1_y_q;
    s1_ts_d  = s1_ts_q;
    s1_pol_d = s1_pol_q;
    if (accept) begin
      s1_x_d   = s_x;
      s1_y_d   = s_y;
      s1_ts_d  = s_ts;
      s1_pol_d = s_pol;
    end
  end

  always_comb begin
    s2_vld_d  = s1_vld_q && ev_ok;
    s2_addr_d = ADDR_BITS'(x_ext * 32'(DVS_HEIGHT) + y_ext);
    s2_data_d = {s1_ts_q, s1_pol_q};
    acc_d     = acc_q;
    drop_d    = drop_q;
    if (s1_vld_q) begin
      if (ev_ok) begin
        if (acc_q != 16'hFFFF) acc_d = acc_q + 16'd1;
      end else begin
        if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
      end
    end
  end

  // Drain empties the event pipe before the clear owns the port
  always_comb begin
    mem_we_d    = s2_vld_q;
    mem_addr_d  = s2_addr_q;
    mem_wdata_d = s2_data_q;
    if (state_q == ST_CLEAR) begin
      mem_we_d    = 1'b1;
      mem_addr_d  = clr_addr_q;
      mem_wdata_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= ST_CLEAR;
      clr_addr_q  <= '0;
      drain_q     <= 1'b0;
      s1_vld_q    <= 1'b0;
      s1_x_q      <= '0;
      s1_y_q      <= '0;
      s1_ts_q     <= '0;
      s1_pol_q    <= '0;
      s2_vld_q    <= 1'b0;
      s2_addr_q   <= '0;
      s2_data_q   <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      acc_q       <= '0;
      drop_q      <= '0;
    end else begin
      state_q     <= state_d;
      clr_addr_q  <= clr_addr_d;
      drain_q     <= drain_d;
      s1_vld_q    <= s1_vld_d;
      s1_x_q      <= s1_x_d;
      s1_y_q      <= s1_y_d;
      s1_ts_q     <= s1_ts_d;
      s1_pol_q    <= s1_pol_d;
      s2_vld_q    <= s2_vld_d;
      s2_addr_q   <= s2_addr_d;
      s2_data_q   <= s2_data_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      acc_q       <= acc_d;
      drop_q      <= drop_d;
    end
  end

endmodule

// File: tb/tb_dvs_event_mem_writer.sv
// Bench for dvs_event_mem_writer: scoreboard of expected writes.
// Narrow sensor (12 x 260) keeps each clear sweep short.
module tb_dvs_event_mem_writer;

  localparam int W     = 12;
  localparam int H     = 260;
  localparam int N_PIX = W * H;

  typedef struct {
    logic [16:0] addr;
    logic [17:0] data;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic        s_valid;
  logic        s_ready;
  logic [8:0]  s_x;
  logic [8:0]  s_y;
  logic [15:0] s_ts;
  logic [1:0]  s_pol;
  logic        clear_start;
  logic        busy;
  logic        mem_we;
  logic [16:0] mem_addr;
  logic [17:0] mem_wdata;
  logic [15:0] accept_cnt;
  logic [15:0] drop_cnt;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  int   clr_exp = 0;

  dvs_event_mem_writer #(.DVS_WIDTH(W)) dut (
    .clk(clk), .rstn(rstn),
    .s_valid(s_valid), .s_ready(s_ready),
    .s_x(s_x), .s_y(s_y), .s_ts(s_ts), .s_pol(s_pol),
    .clear_start(clear_start), .busy(busy),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .accept_cnt(accept_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Monitor: zero words are clear writes, anything else is an event
  always @(negedge clk) begin
    if (rstn && mem_we) begin
      if (mem_wdata == '0) begin
        chk("clear_addr", 64'(mem_addr), 64'(clr_exp));
        clr_exp++;
      end else if (q.size() == 0) begin
        chk("unexpected_write", 64'(mem_addr), 64'h0);
        chk("unexpected_data", 64'(mem_wdata), 64'h0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("ev_addr", 64'(mem_addr), 64'(e.addr));
        chk("ev_data", 64'(mem_wdata), 64'(e.data));
        chk("ev_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic send(input logic [8:0] x, input logic [8:0] y,
                      input logic [15:0] ts, input logic [1:0] pol,
                      input bit wr, input logic [16:0] a,
                      input logic [17:0] d);
    exp_t e;
    @(negedge clk);
    s_valid = 1'b1;
    s_x = x; s_y = y; s_ts = ts; s_pol = pol;
    if (wr) begin
      e.addr = a; e.data = d; e.cyc = cyc + 3;
      q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      s_valid = 1'b0;
    end
  endtask

  task automatic wait_clear_done(input string nm);
    int k;
    k = 0;
    while (busy && k < N_PIX + 20) begin
      @(negedge clk);
      k++;
    end
    chk({nm, "_busy"}, 64'(busy), 64'h0);
    @(negedge clk);
    chk({nm, "_count"}, 64'(clr_exp), 64'(N_PIX));
    chk({nm, "_ready"}, 64'(s_ready), 64'h1);
  endtask

  task automatic chk_reset_state();
    chk("rst_we", 64'(mem_we), 64'h0);
    chk("rst_addr", 64'(mem_addr), 64'h0);
    chk("rst_wdata", 64'(mem_wdata), 64'h0);
    chk("rst_acc", 64'(accept_cnt), 64'h0);
    chk("rst_drop", 64'(drop_cnt), 64'h0);
    chk("rst_busy", 64'(busy), 64'h1);
    chk("rst_ready", 64'(s_ready), 64'h0);
  endtask

  logic [16:0] bb_addr [8] = '{260, 522, 784, 1046, 1308, 1570, 1832, 2094};
  logic [17:0] bb_data [8] = '{18'h401, 18'h406, 18'h409, 18'h40E,
                               18'h411, 18'h416, 18'h419, 18'h41E};

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; s_valid = 1'b0; clear_start = 1'b0;
    s_x = '0; s_y = '0; s_ts = '0; s_pol = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_reset_state();
    @(negedge clk);
    rstn = 1'b1;
    clr_exp = 0;
    wait_clear_done("clear_after_reset");

    send(9'd5, 9'd7, 16'h1234, 2'b01, 1, 17'd1307, 18'h048D1);
    idle(4);
    chk("acc_single", 64'(accept_cnt), 64'd1);

    send(9'd0, 9'd0, 16'hABCD, 2'b10, 1, 17'd0, 18'h2AF36);
    send(9'd11, 9'd259, 16'hFFFF, 2'b10, 1, 17'd3119, 18'h3FFFE);
    idle(4);
    chk("acc_corner", 64'(accept_cnt), 64'd3);

    send(9'd12, 9'd0, 16'h0001, 2'b01, 0, '0, '0);
    send(9'd0, 9'd260, 16'h0002, 2'b01, 0, '0, '0);
    send(9'd1, 9'd1, 16'h0003, 2'b00, 0, '0, '0);
    send(9'd1, 9'd1, 16'h0004, 2'b11, 0, '0, '0);
    idle(4);
    chk("drop_cnt", 64'(drop_cnt), 64'd4);
    chk("acc_after_drop", 64'(accept_cnt), 64'd3);

    for (int i = 0; i < 8; i++)
      send(9'(i + 1), 9'(2 * i), 16'(16'h100 + i),
           (i % 2 == 0) ? 2'b01 : 2'b10, 1, bb_addr[i], bb_data[i]);
    idle(4);
    chk("acc_burst", 64'(accept_cnt), 64'd11);

    clr_exp = 0;
    send(9'd1, 9'd1, 16'h0011, 2'b01, 1, 17'd261, 18'h00045);
    send(9'd2, 9'd3, 16'h0022, 2'b10, 1, 17'd523, 18'h0008A);
    @(negedge clk);
    s_x = 9'd3; s_y = 9'd3; s_ts = 16'h0033; s_pol = 2'b01;
    clear_start = 1'b1;
    #1;
    chk("ready_on_clear", 64'(s_ready), 64'h0);
    @(negedge clk);
    clear_start = 1'b0;
    s_valid = 1'b0;
    wait_clear_done("clear_req");
    chk("acc_keep", 64'(accept_cnt), 64'd13);
    chk("drop_keep", 64'(drop_cnt), 64'd4);
    chk("queue_empty", 64'(q.size()), 64'd0);

    clr_exp = 0;
    @(negedge clk);
    clear_start = 1'b1;
    @(negedge clk);
    clear_start = 1'b0;
    repeat (200) @(negedge clk);
    clear_start = 1'b1;
    @(negedge clk);
    clear_start = 1'b0;
    repeat (100) @(negedge clk);
    chk("partial_clear", 64'(clr_exp > 250), 64'h1);
    rstn = 1'b0;
    @(posedge clk);
    #1;
    clr_exp = 0;
    chk_reset_state();
    @(negedge clk);
    rstn = 1'b1;
    wait_clear_done("clear_restart");
    chk("final_queue", 64'(q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
